// File: rtl/mmio_arbiter_if.sv
// ---------------------------------------------------------------------------
// mmio_arbiter_if
// Bundles the two requesting-master ports and the FPro MMIO bus of the
// arbiter into one interface.
//   m0_*/m1_*     : request/ack handshake and data of masters 0 and 1
//   mmio_*        : FPro bus strobes, address and data towards the MMIO slots
//   busy          : arbiter is not IDLE
// Modports:
//   slave  - the arbiter's view: it serves the two masters and drives the bus
//   master - the environment's view: the two masters plus the MMIO slot
// ---------------------------------------------------------------------------
interface mmio_arbiter_if #(
    parameter int ADDR_W = 21,
    parameter int DATA_W = 32
);
    logic              m0_req,     m1_req;
    logic              m0_wr,      m1_wr;
    logic [ADDR_W-1:0] m0_addr,    m1_addr;
    logic [DATA_W-1:0] m0_wr_data, m1_wr_data;
    logic              m0_ack,     m1_ack;
    logic [DATA_W-1:0] m0_rd_data, m1_rd_data;

    logic              mmio_cs, mmio_wr, mmio_rd;
    logic [ADDR_W-1:0] mmio_addr;
    logic [DATA_W-1:0] mmio_wr_data;
    logic [DATA_W-1:0] mmio_rd_data;

    logic              busy;

    modport slave (
        input  m0_req, m1_req, m0_wr, m1_wr, m0_addr, m1_addr,
               m0_wr_data, m1_wr_data, mmio_rd_data,
        output m0_ack, m1_ack, m0_rd_data, m1_rd_data,
               mmio_cs, mmio_wr, mmio_rd, mmio_addr, mmio_wr_data, busy
    );

    modport master (
        output m0_req, m1_req, m0_wr, m1_wr, m0_addr, m1_addr,
               m0_wr_data, m1_wr_data, mmio_rd_data,
        input  m0_ack, m1_ack, m0_rd_data, m1_rd_data,
               mmio_cs, mmio_wr, mmio_rd, mmio_addr, mmio_wr_data, busy
    );
endinterface

// File: rtl/mmio_arbiter.sv
// ---------------------------------------------------------------------------
// mmio_arbiter
// Two-master arbiter in front of an FPro MMIO bus. Each transaction runs a
// fixed IDLE -> ISSUE -> ACK sequence: request sampled in IDLE, one strobe
// cycle in ISSUE (read data captured at its end), one ack pulse in ACK.
// Ports:
//   clk    : system clock, rising edge
//   reset  : synchronous, active-low
//   bus    : mmio_arbiter_if.slave (master handshakes + MMIO bus + busy)
// Configuration macro:
//   MMIO_ARB_FIXED_PRIO_EN - defined: master 0 always wins a tie and the
//                            last-grant register is removed;
//                            undefined: round-robin on ties.
// ---------------------------------------------------------------------------
module mmio_arbiter #(
    parameter int ADDR_W = 21,
    parameter int DATA_W = 32
) (
    input  logic           clk,
    input  logic           reset,
    mmio_arbiter_if.slave  bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] ACK   = 2'd2;

    logic [1:0]        state_q,  state_d;
    logic              id_q,     id_d;      // latched master: 0 or 1
    logic              wr_q,     wr_d;
    logic [ADDR_W-1:0] addr_q,   addr_d;
    logic [DATA_W-1:0] wdata_q,  wdata_d;
    logic [DATA_W-1:0] rd0_q,    rd0_d;
    logic [DATA_W-1:0] rd1_q,    rd1_d;
    logic              winner;
`ifndef MMIO_ARB_FIXED_PRIO_EN
    logic              last_q,   last_d;    // master granted most recently
`endif

    // Winner among the current requests; only used when at least one is high.
    always_comb begin
`ifdef MMIO_ARB_FIXED_PRIO_EN
        winner = ~bus.m0_req;
`else
        if (bus.m0_req && bus.m1_req) winner = ~last_q;
        else                          winner = bus.m1_req;
`endif
    end

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        state_d = state_q;
        id_d    = id_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rd0_d   = rd0_q;
        rd1_d   = rd1_q;
`ifndef MMIO_ARB_FIXED_PRIO_EN
        last_d  = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.m0_req || bus.m1_req) begin
                    state_d = ISSUE;
                    id_d    = winner;
                    wr_d    = winner ? bus.m1_wr      : bus.m0_wr;
                    addr_d  = winner ? bus.m1_addr    : bus.m0_addr;
                    wdata_d = winner ? bus.m1_wr_data : bus.m0_wr_data;
`ifndef MMIO_ARB_FIXED_PRIO_EN
                    last_d  = winner;
`endif
                end
            end
            ISSUE: begin
                state_d = ACK;
                // Slot read data is combinational and valid in this cycle.
                if (!wr_q) begin
                    if (id_q) rd1_d = bus.mmio_rd_data;
                    else      rd0_d = bus.mmio_rd_data;
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge value of the others.
        if (!reset) begin
            state_q <= IDLE;
            id_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rd0_q   <= '0;
            rd1_q   <= '0;
`ifndef MMIO_ARB_FIXED_PRIO_EN
            last_q  <= 1'b1;   // master 0 wins the first tie
`endif
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rd0_q   <= rd0_d;
            rd1_q   <= rd1_d;
`ifndef MMIO_ARB_FIXED_PRIO_EN
            last_q  <= last_d;
`endif
        end
    end

    // Strobes, acks and busy are gated by reset so an abort is silent even
    // in the cycle in which reset is still being sampled.
    logic in_issue, in_ack;
    assign in_issue = reset && (state_q == ISSUE);
    assign in_ack   = reset && (state_q == ACK);

    assign bus.mmio_cs      = in_issue;
    assign bus.mmio_wr      = in_issue &&  wr_q;
    assign bus.mmio_rd      = in_issue && !wr_q;
    assign bus.mmio_addr    = addr_q;
    assign bus.mmio_wr_data = wdata_q;
    assign bus.m0_ack       = in_ack && !id_q;
    assign bus.m1_ack       = in_ack &&  id_q;
    assign bus.m0_rd_data   = rd0_q;
    assign bus.m1_rd_data   = rd1_q;
    assign bus.busy         = reset && (state_q != IDLE);
endmodule

// File: tb/tb_mmio_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mmio_arbiter
// Scoreboard bench for mmio_arbiter: expected transactions are pushed when
// requests are driven, popped when the strobe appears, then matched against
// the ack. A small MMIO slot model answers reads from the address.
// ---------------------------------------------------------------------------
module tb_mmio_arbiter;
    localparam int ADDR_W = 21;
    localparam int DATA_W = 32;

    typedef struct {
        bit              id;
        bit              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] rdata;
        int              exp_cyc;     // expected strobe cycle, -1 = any
        int              strobe_cyc;
    } txn_t;

    logic clk;
    logic reset;
    int   cyc;
    int   n_checks;
    int   n_pass;
    int   ack_cnt;
    bit   tb_last;
    logic [DATA_W-1:0] exp_rd0, exp_rd1;
    txn_t sq[$];
    txn_t aq[$];

    mmio_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mmio_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DATA_W-1:0] slot_read(input logic [ADDR_W-1:0] a);
        if (a == 21'h00180) return 32'hDEAD_BEEF;
        return {11'h5A5, a};
    endfunction

    assign bus.mmio_rd_data = slot_read(bus.mmio_addr);

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Monitor: strobe/ack protocol, scoreboard matching, rd_data hold.
    always @(negedge clk) begin
        txn_t e;
        if (!reset) begin
            check("rst_cs",   64'(bus.mmio_cs), 64'(0));
            check("rst_ack",  64'({bus.m0_ack, bus.m1_ack}), 64'(0));
            check("rst_busy", 64'(bus.busy), 64'(0));
        end else begin
            if (bus.mmio_cs) check("wr_rd_onehot", 64'(bus.mmio_wr ^ bus.mmio_rd), 64'(1));
            else             check("strobe_low", 64'({bus.mmio_wr, bus.mmio_rd}), 64'(0));
            check("ack_excl", 64'(bus.m0_ack & bus.m1_ack), 64'(0));
            if (bus.mmio_cs) begin
                check("busy_issue", 64'(bus.busy), 64'(1));
                if (sq.size() == 0) check("unexp_strobe", 64'(1), 64'(0));
                else begin
                    e = sq.pop_front();
                    check("strobe_wr",   64'(bus.mmio_wr), 64'(e.wr));
                    check("strobe_addr", 64'(bus.mmio_addr), 64'(e.addr));
                    if (e.wr) check("strobe_wdata", 64'(bus.mmio_wr_data), 64'(e.wdata));
                    if (e.exp_cyc >= 0) check("strobe_cycle", 64'(cyc), 64'(e.exp_cyc));
                    e.strobe_cyc = cyc;
                    aq.push_back(e);
                end
            end
            if (bus.m0_ack || bus.m1_ack) begin
                check("busy_ack", 64'(bus.busy), 64'(1));
                if (aq.size() == 0) check("unexp_ack", 64'(1), 64'(0));
                else begin
                    e = aq.pop_front();
                    check("ack_id",    64'(bus.m1_ack), 64'(e.id));
                    check("ack_cycle", 64'(cyc), 64'(e.strobe_cyc + 1));
                    if (!e.wr) begin
                        if (e.id) exp_rd1 = e.rdata;
                        else      exp_rd0 = e.rdata;
                    end
                end
                ack_cnt++;
            end
            check("m0_rd_data", 64'(bus.m0_rd_data), 64'(exp_rd0));
            check("m1_rd_data", 64'(bus.m1_rd_data), 64'(exp_rd1));
        end
    end

    function automatic txn_t mk(input bit id, input bit wr, input logic [ADDR_W-1:0] a,
                                input logic [DATA_W-1:0] d, input int exp_cyc);
        txn_t t;
        t.id = id; t.wr = wr; t.addr = a; t.wdata = d;
        t.rdata = slot_read(a); t.exp_cyc = exp_cyc; t.strobe_cyc = 0;
        return t;
    endfunction

    task automatic drive(input bit id, input bit wr, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d);
        if (id) begin
            bus.m1_req = 1'b1; bus.m1_wr = wr; bus.m1_addr = a; bus.m1_wr_data = d;
        end else begin
            bus.m0_req = 1'b1; bus.m0_wr = wr; bus.m0_addr = a; bus.m0_wr_data = d;
        end
    endtask

    // Returns one cycle after the target ack count was reached (at a posedge),
    // early enough for the caller to drop requests before IDLE samples them.
    task automatic wait_acks(input int target, input int budget);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(posedge clk);
            if (ack_cnt >= target) done = 1'b1;
        end
        if (!done) check("ack_timeout", 64'(ack_cnt), 64'(target));
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        sq.delete(); aq.delete();
        exp_rd0 = '0; exp_rd1 = '0; tb_last = 1'b1;
        bus.m0_req = 1'b0; bus.m1_req = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic do_single(input bit id, input bit wr, input logic [ADDR_W-1:0] a,
                             input logic [DATA_W-1:0] d);
        @(posedge clk); #1;
        drive(id, wr, a, d);
        tb_last = id;
        sq.push_back(mk(id, wr, a, d, cyc + 1));
        wait_acks(ack_cnt + 1, 10);
        bus.m0_req = 1'b0; bus.m1_req = 1'b0;
    endtask

    initial begin
        bit w;
        n_checks = 0; n_pass = 0; ack_cnt = 0;
        reset = 1'b0;
        exp_rd0 = '0; exp_rd1 = '0; tb_last = 1'b1;
        bus.m0_req = 0; bus.m0_wr = 0; bus.m0_addr = '0; bus.m0_wr_data = '0;
        bus.m1_req = 0; bus.m1_wr = 0; bus.m1_addr = '0; bus.m1_wr_data = '0;

        do_reset();
        @(negedge clk);
        check("reset_busy",   64'(bus.busy), 64'(0));
        check("reset_addr",   64'(bus.mmio_addr), 64'(0));
        check("reset_wdata",  64'(bus.mmio_wr_data), 64'(0));
        check("reset_rd0",    64'(bus.m0_rd_data), 64'(0));
        check("reset_rd1",    64'(bus.m1_rd_data), 64'(0));

        // Single write, then reads on both masters.
        do_single(1'b0, 1'b1, 21'h000C2, 32'hA5A5_0001);
        do_single(1'b0, 1'b0, 21'h00044, 32'h0);
        do_single(1'b1, 1'b0, 21'h00180, 32'h0);

        // Back-to-back: m0 holds req through the first ack.
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 21'h00200, 32'h1234_5678);
        tb_last = 1'b0;
        sq.push_back(mk(1'b0, 1'b1, 21'h00200, 32'h1234_5678, cyc + 1));
        sq.push_back(mk(1'b0, 1'b1, 21'h00200, 32'h1234_5678, cyc + 4));
        wait_acks(ack_cnt + 2, 12);
        bus.m0_req = 1'b0;

        // Drop and change the request right after it was latched.
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 21'h00333, 32'hCAFE_0003);
        sq.push_back(mk(1'b0, 1'b1, 21'h00333, 32'hCAFE_0003, cyc + 1));
        @(posedge clk); #1;
        bus.m0_req = 1'b0; bus.m0_addr = 21'h1FFFFF; bus.m0_wr = 1'b0;
        bus.m0_wr_data = 32'hFFFF_FFFF;
        wait_acks(ack_cnt + 1, 10);

        // Contention straight after reset: both masters request continuously.
        do_reset();
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 21'h00010, 32'h1111_0000);
        drive(1'b1, 1'b0, 21'h00020, 32'h0);
        for (int k = 0; k < 4; k++) begin
`ifdef MMIO_ARB_FIXED_PRIO_EN
            w = 1'b0;
`else
            w = ~tb_last;
`endif
            tb_last = w;
            if (w) sq.push_back(mk(1'b1, 1'b0, 21'h00020, 32'h0, cyc + 1 + 3 * k));
            else   sq.push_back(mk(1'b0, 1'b1, 21'h00010, 32'h1111_0000, cyc + 1 + 3 * k));
        end
        wait_acks(ack_cnt + 4, 20);
        bus.m0_req = 1'b0; bus.m1_req = 1'b0;

        // A handful of random single transactions.
        for (int i = 0; i < 6; i++) begin
            do_single(1'($urandom_range(1)), 1'($urandom_range(1)),
                      21'($urandom_range(21'h1FFFFF)), $urandom);
        end

        // Reset asserted while the strobe would be on the bus.
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 21'h00180, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        bus.m1_req = 1'b0;
        sq.delete(); aq.delete();
        exp_rd0 = '0; exp_rd1 = '0; tb_last = 1'b1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("abort_busy", 64'(bus.busy), 64'(0));
        check("abort_cs",   64'(bus.mmio_cs), 64'(0));
        check("abort_ack",  64'({bus.m0_ack, bus.m1_ack}), 64'(0));
        check("abort_rd1",  64'(bus.m1_rd_data), 64'(0));
        repeat (3) @(posedge clk);
        do_single(1'b1, 1'b0, 21'h00180, 32'h0);

        repeat (3) @(posedge clk);
        check("strobe_q_empty", 64'(sq.size()), 64'(0));
        check("ack_q_empty",    64'(aq.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
